// File: rtl/vit_frame_ctrl.sv
// Frame sequencer for a hard-decision Viterbi decoder: paces symbols into the
// branch-metric/ACS datapath, launches traceback and watches it for a timeout.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting FRAME_LEN symbol pairs
// FLUSH | last ACS step in flight
// TB    | traceback running, timeout counting
// DONE  | frame_done pulse
module vit_frame_ctrl #(
    parameter int FRAME_LEN  = 16,
    parameter int TB_TIMEOUT = 64,
    localparam int CW = $clog2(FRAME_LEN),
    localparam int TW = $clog2(TB_TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [1:0]    rx_pair,
    output logic          in_ready,
    output logic [1:0]    bmc_rx,
    output logic          acs_en,
    output logic [CW-1:0] step_cnt,
    output logic          tb_start,
    input  logic          tb_done,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_TB    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] SYM_LAST = CW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TB_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TB_TIMEOUT);

    logic [2:0]    state;
    logic [CW-1:0] sym_cnt;
    logic [TW-1:0] to_cnt;
    logic          hs;

    assign in_ready   = (state == S_RUN);
    assign hs         = in_ready & in_valid;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sym_cnt  <= '0;
            to_cnt   <= '0;
            bmc_rx   <= 2'b00;
            acs_en   <= 1'b0;
            step_cnt <= '0;
            tb_start <= 1'b0;
            err      <= 1'b0;
        end else begin
            acs_en   <= hs;
            tb_start <= 1'b0;

            if (hs) begin
                bmc_rx   <= rx_pair;
                step_cnt <= sym_cnt;
                if (sym_cnt != SYM_LAST)
                    sym_cnt <= sym_cnt + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        sym_cnt <= '0;
                        err     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (hs && (sym_cnt == SYM_LAST))
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    state    <= S_TB;
                    tb_start <= 1'b1;
                    to_cnt   <= '0;
                end
                S_TB: begin
                    // tb_start doubles as the first-TB-cycle marker; tb_done is not trusted then
                    if (!tb_start && tb_done) begin
                        state <= S_DONE;
                    end else begin
                        if (to_cnt == TO_LAST) begin
                            state <= S_IDLE;
                            err   <= 1'b1;
                        end
                        if (to_cnt != TO_MAX)
                            to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vit_frame_ctrl.sv
// Bench for vit_frame_ctrl (FRAME_LEN=4, TB_TIMEOUT=8): directed and random frames
// checked cycle by cycle against a cycle-arithmetic model of the frame timeline.
module tb_vit_frame_ctrl;

    localparam int L  = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [1:0] rx_pair;
    logic       in_ready;
    logic [1:0] bmc_rx;
    logic       acs_en;
    logic [1:0] step_cnt;
    logic       tb_start;
    logic       tb_done;
    logic       busy;
    logic       frame_done;
    logic       err;

    vit_frame_ctrl #(.FRAME_LEN(L), .TB_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .rx_pair(rx_pair),
        .in_ready(in_ready), .bmc_rx(bmc_rx), .acs_en(acs_en), .step_cnt(step_cnt),
        .tb_start(tb_start), .tb_done(tb_done), .busy(busy), .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int m_step = 0;
    int m_bmc  = 0;
    bit m_err  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the current IDLE cycle; start is sampled at its closing edge.
    // k: TB-cycle index (0 = tb_start cycle) at which tb_done is raised.
    task automatic frame(input bit rnd, input int k, input int gap_after, input bit hold);
        int  nacc     = 0;
        int  last_acc = -10;
        int  t0       = -1;
        int  done_c   = -1;
        int  end_c    = -1;
        int  gap_left = 0;
        bit  finished = 1'b0;
        chk("pre_busy", 32'(busy), 0);
        chk("pre_ready", 32'(in_ready), 0);
        chk("pre_err", 32'(err), 32'(m_err));
        start    = 1'b1;
        in_valid = rnd ? (($urandom % 2) != 0) : 1'b0;
        rx_pair  = 2'($urandom);
        tb_done  = 1'b0;
        m_err    = 1'b0;
        for (int c = 1; c < 200 && !finished; c++) begin
            tick();
            if (end_c == c && done_c < 0) m_err = 1'b1;
            chk("in_ready", 32'(in_ready), 32'(nacc < L));
            chk("acs_en", 32'(acs_en), 32'(last_acc == c - 1));
            chk("step_cnt", 32'(step_cnt), 32'(m_step));
            chk("bmc_rx", 32'(bmc_rx), 32'(m_bmc));
            chk("tb_start", 32'(tb_start), 32'(t0 == c));
            chk("frame_done", 32'(frame_done), 32'(done_c == c));
            chk("busy", 32'(busy), 32'(end_c != c));
            chk("err", 32'(err), 32'(m_err));
            if (end_c == c) begin
                start    = hold;
                in_valid = 1'b0;
                tb_done  = 1'b0;
                finished = 1'b1;
            end else begin
                start   = hold ? 1'b1 : (rnd ? (($urandom % 2) != 0) : 1'b0);
                rx_pair = rnd ? 2'($urandom) : 2'(nacc);
                if (rnd) begin
                    in_valid = (($urandom % 3) != 0);
                end else if (gap_left > 0) begin
                    in_valid = 1'b0;
                    gap_left--;
                end else begin
                    in_valid = 1'b1;
                end
                tb_done = (t0 >= 0) && (c == t0 + k);
                if (nacc < L && in_valid) begin
                    m_step   = nacc;
                    m_bmc    = int'(rx_pair);
                    last_acc = c;
                    if (nacc == gap_after) gap_left = 3;
                    nacc++;
                    if (nacc == L) begin
                        t0 = c + 2;
                        if (k < 1 || k > TO - 1) end_c = t0 + TO;
                    end
                end
                if (tb_done && k >= 1 && k <= TO - 1) begin
                    done_c = c + 1;
                    end_c  = c + 2;
                end
            end
        end
        if (!finished) chk("frame_bound", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start    = 1'b0;
            in_valid = (($urandom % 2) != 0);
            tb_done  = 1'b0;
            tick();
            chk("idle_busy", 32'(busy), 0);
            chk("idle_ready", 32'(in_ready), 0);
            chk("idle_acs", 32'(acs_en), 0);
            chk("idle_fd", 32'(frame_done), 0);
            chk("idle_err", 32'(err), 32'(m_err));
            chk("idle_step", 32'(step_cnt), 32'(m_step));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_bmc"}, 32'(bmc_rx), 0);
        chk({tag, "_acs"}, 32'(acs_en), 0);
        chk({tag, "_step"}, 32'(step_cnt), 0);
        chk({tag, "_tbs"}, 32'(tb_start), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fd"}, 32'(frame_done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        rx_pair  = 2'b00;
        tb_done  = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        #2 rst = 1'b0;

        frame(1'b0, 2, -1, 1'b0);     // nominal frame, tb_done in third TB cycle
        idle(2);
        frame(1'b0, 3, 1, 1'b0);      // 3-cycle gap between symbols 1 and 2
        frame(1'b0, 100, -1, 1'b0);   // traceback never finishes
        frame(1'b0, 1, -1, 1'b0);     // start clears err
        frame(1'b0, 0, -1, 1'b0);     // tb_done only in the tb_start cycle

        // reset mid-frame after two accepted symbols
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        rx_pair  = 2'd1;
        tick();
        rx_pair = 2'd2;
        tick();
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        in_valid = 1'b0;
        tick();
        chk_all_zero("midrst_hold");
        #2 rst = 1'b0;
        m_step = 0;
        m_bmc  = 0;
        m_err  = 1'b0;
        frame(1'b0, 2, -1, 1'b0);

        frame(1'b0, 2, -1, 1'b1);     // start held high across frames
        frame(1'b0, TO - 1, -1, 1'b1); // tb_done and timeout on the same edge
        frame(1'b0, 2, -1, 1'b0);
        idle(1);

        for (int n = 0; n < 12; n++) begin
            bit h;
            h = (($urandom % 2) != 0);
            frame(1'b1, $urandom_range(0, 10), -1, h);
            if (!h) idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
